bcd_to_binary: RTL and testbench

- Multi-cycle BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any digit >= 8).
- Inverse of the existing binary-to-BCD path: converts NDIG packed BCD digits (ones at LSB, up to millions) to a BIN_W-bit unsigned value.
- Sits between the keypad/switch digit-entry logic and the arithmetic/display datapath.
- Uses a start/ready/done handshake and flags invalid digits (> 9).

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_sub3.sv | 10 +
 rtl/bcd_to_binary.sv | 105 ++++++++++
 tb/tb_bcd_to_binary.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
package bcd_pkg;

  // Default operand size: seven BCD digits (0..9999999) into 24 bits
  localparam int DEF_NDIG  = 7;
  localparam int DEF_BIN_W = 24;
  localparam int CNT_W     = $clog2(DEF_BIN_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 1 for a legal decimal digit (0..9)
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One digit of the reverse double-dabble adjust: digits that landed at 8 or
// above after the right shift had a 10 folded in as 16, so take 3 back off.
module bcd_digit_sub3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double-dabble).
// One bit per clock is shifted out of the BCD register into the binary
// register; each digit is then corrected by the per-digit subtract-3 units.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NDIG  = DEF_NDIG,
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BIN_W-1:0]  bin_out
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CW    = $clog2(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  state_t           state;
  logic [BCD_W-1:0] bcd_sr;
  logic [BIN_W-1:0] bin_sr;
  logic [CW-1:0]    cnt;

  logic [BCD_W-1:0] sh_bcd;
  logic [BCD_W-1:0] adj_bcd;
  logic [BIN_W-1:0] sh_bin;
  logic             bad;

  // One step of the joint right shift: BCD LSB drops into binary MSB.
  // The bit leaving bin_sr is always zero within BIN_W steps.
  assign sh_bcd = bcd_sr >> 1;
  assign sh_bin = BIN_W'({bcd_sr[0], bin_sr} >> 1);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_sub3 u_sub3 (
      .din  (sh_bcd[4*g +: 4]),
      .dout (adj_bcd[4*g +: 4])
    );
  end

  // Flag an operand containing any digit above 9
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (!is_bcd_digit(bcd_in[4*k +: 4])) bad = 1'b1;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);

  // Control FSM, step counter, shift registers and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_sr <= bcd_in;
            bin_sr <= '0;
            cnt    <= '0;
            if (bad) begin
              err     <= 1'b1;
              bin_out <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              err   <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_sr <= adj_bcd;
          bin_sr <= sh_bin;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bin_out <= sh_bin;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: vector table, handshake corner
// cases, mid-conversion reset and randomized back-to-back traffic.
module tb_bcd_to_binary;

  localparam int NDIG  = 7;
  localparam int BIN_W = 24;
  localparam int BCD_W = 4 * NDIG;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BCD_W-1:0]  bcd_in;
  logic              ready, busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  int tests = 0;
  int fails = 0;

  bcd_to_binary #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic [BIN_W-1:0] bin;
    logic             bad;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, error if any digit exceeds 9
  function automatic void model(input logic [BCD_W-1:0] b,
                                output logic [BIN_W-1:0] v, output logic e);
    longint acc = 0;
    e = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      int d = int'(b[4*k +: 4]);
      if (d > 9) e = 1'b1;
      acc = acc * 10 + d;
    end
    v = e ? '0 : BIN_W'(acc);
  endfunction

  function automatic logic [BCD_W-1:0] rand_valid();
    logic [BCD_W-1:0] b = '0;
    for (int k = 0; k < NDIG; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // Called at a negedge. Issues one request and checks latency, busy
  // duration and the result. Done must appear BIN_W edges after accept
  // (the negedge after accept is count 1), or right after accept on error.
  task automatic convert(input logic [BCD_W-1:0] b, input logic [BIN_W-1:0] ev,
                         input logic ee, input string nm);
    int n, nb;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    check({nm, " ready"}, 32'(ready), 32'd1);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = BCD_W'($urandom);
    n  = 1;
    nb = int'(busy);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end
    check({nm, " latency"}, 32'(n), ee ? 32'd1 : 32'(BIN_W + 1));
    check({nm, " busy cycles"}, 32'(nb), ee ? 32'd0 : 32'(BIN_W));
    check({nm, " bin_out"}, 32'(bin_out), 32'(ev));
    check({nm, " err"}, 32'(err), 32'(ee));
    @(negedge clk);
    check({nm, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [BIN_W-1:0] ev;
    logic             ee;
    logic [BCD_W-1:0] b;
    int n, ndone, done_at;

    vecs[0] = '{28'h0000000, 24'h000000, 1'b0};
    vecs[1] = '{28'h1234567, 24'h12D687, 1'b0};
    vecs[2] = '{28'h9999999, 24'h98967F, 1'b0};
    vecs[3] = '{28'h0039062, 24'h009896, 1'b0};
    vecs[4] = '{28'h00000A0, 24'h000000, 1'b1};
    vecs[5] = '{28'h0000042, 24'h00002A, 1'b0};
    vecs[6] = '{28'h0000009, 24'h000009, 1'b0};
    vecs[7] = '{28'hF000000, 24'h000000, 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset bin_out", 32'(bin_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) convert(vecs[i].bcd, vecs[i].bin, vecs[i].bad, $sformatf("vec%0d", i));

    // Randomized single conversions, some with an illegal digit
    for (int r = 0; r < 10; r++) begin
      b = rand_valid();
      if ($urandom_range(0, 3) == 0) b[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
      model(b, ev, ee);
      convert(b, ev, ee, $sformatf("rand%0d", r));
    end

    // Extra start pulses and bcd_in changes while converting are ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 28'h1234567;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin ndone++; done_at = c; end
      if (c == 26) check("ignore ready after done", 32'(ready), 32'd1);
      if (c == 25) check("ignore ready in DONE", 32'(ready), 32'd0);
      start  = (c == 3 || c == 10 || c == 24);
      bcd_in = BCD_W'($urandom);
      @(negedge clk);
      if (c == 26) start = 1'b0;
    end
    start = 1'b0;
    check("ignore done count", 32'(ndone), 32'd1);
    check("ignore done time", 32'(done_at), 32'(BIN_W + 1));
    check("ignore bin_out", 32'(bin_out), 32'h12D687);

    // Reset in the middle of a conversion
    start  = 1'b1;
    bcd_in = 28'h1234567;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst bin_out", 32'(bin_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst no done", 32'(ndone), 32'd0);
    convert(28'h0000042, 24'h00002A, 1'b0, "post-reset");

    // Back-to-back with start held high
    begin
      logic [BCD_W-1:0] q[$];
      int last, got;
      last = -1;
      got  = 0;
      start = 1'b1;
      for (int c = 0; c < 400 && got < 8; c++) begin
        if (ready) begin
          b = rand_valid();
          bcd_in = b;
          q.push_back(b);
        end
        @(negedge clk);
        if (done) begin
          if (q.size() != 0) b = q.pop_front();
          model(b, ev, ee);
          check($sformatf("b2b%0d bin_out", got), 32'(bin_out), 32'(ev));
          check($sformatf("b2b%0d err", got), 32'(err), 32'd0);
          if (last >= 0) check($sformatf("b2b%0d period", got), 32'(c - last), 32'(BIN_W + 2));
          last = c;
          got++;
        end
      end
      start = 1'b0;
      check("b2b conversions seen", 32'(got), 32'd8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
